// File: rtl/bert_pkg.sv
// Shared state encoding and parameter defaults for the BERT input-sync controller.
`default_nettype none

package bert_pkg;

  localparam int DEF_FLUSH_CYCLES = 8;
  localparam int DEF_PRIME_BITS   = 4;
  localparam int DEF_LOSS_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_PRIME = 3'd2,
    ST_RUN   = 3'd3,
    ST_LOST  = 3'd4
  } bert_state_e;

endpackage

`default_nettype wire

// File: rtl/bert_sync_ctrl.sv
// Flush/prime/run sequencer for the BERT input sync stage, with clock-loss
// watchdog and source-select handling. Rev 1.0.
`default_nettype none

module bert_sync_ctrl
  import bert_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int PRIME_BITS   = DEF_PRIME_BITS,
  parameter int LOSS_TIMEOUT = DEF_LOSS_TIMEOUT
) (
  input  logic       rd_clk,
  input  logic       reset,
  input  logic [1:0] src_sel,
  input  logic       sel_strobe,
  input  logic       sync_enable,
  input  logic       sync_empty,
  input  logic       sync_full,
  output logic       sync_rst,
  output logic [1:0] mux_sel,
  output logic       bit_valid,
  output logic       locked,
  output logic       clk_lost,
  output logic [7:0] resync_count
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int PW = (PRIME_BITS > 1) ? $clog2(PRIME_BITS) : 1;
  localparam int WW = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_BITS - 1);
  localparam logic [WW-1:0] WD_LIMIT   = WW'(LOSS_TIMEOUT);

  bert_state_e   state_q, state_d;
  logic [1:0]    mux_sel_q, mux_sel_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [PW-1:0] prime_cnt_q, prime_cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    resync_q, resync_d;
  logic          sync_rst_q, sync_rst_d;
  logic          locked_q, locked_d;
  logic          clk_lost_q, clk_lost_d;

  logic bit_ok;
  logic src_change;
  logic wd_expired;

  assign bit_ok     = sync_enable & ~sync_empty;
  assign src_change = sel_strobe & (src_sel != mux_sel_q);
  assign wd_expired = (wd_d == WD_LIMIT);

  always_comb begin
    state_d     = state_q;
    mux_sel_d   = mux_sel_q;
    flush_cnt_d = '0;
    prime_cnt_d = '0;
    resync_d    = resync_q;

    // Saturating watchdog; parked at zero while LOST waits for the clock to return.
    if (state_q == ST_LOST || sync_enable) begin
      wd_d = '0;
    end else if (wd_q != WD_LIMIT) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end

    case (state_q)
      ST_IDLE: state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_PRIME;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_PRIME: begin
        if (wd_expired) begin
          state_d = ST_LOST;
        end else if (bit_ok) begin
          if (prime_cnt_q == PRIME_LAST) begin
            state_d = ST_RUN;
          end else begin
            prime_cnt_d = prime_cnt_q + 1'b1;
          end
        end else begin
          prime_cnt_d = prime_cnt_q;
        end
      end
      ST_RUN: begin
        if (wd_expired) begin
          state_d = ST_LOST;
        end else if (sync_full || (sync_enable && sync_empty)) begin
          state_d = ST_FLUSH;
          if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
        end
      end
      ST_LOST: begin
        if (sync_enable) state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;
    endcase

    // A real source change outranks everything except reset.
    if (src_change) begin
      mux_sel_d   = src_sel;
      state_d     = ST_FLUSH;
      flush_cnt_d = '0;
      prime_cnt_d = '0;
      resync_d    = resync_q;
    end

    sync_rst_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH) || (state_d == ST_LOST);
    locked_d   = (state_d == ST_RUN);
    clk_lost_d = (state_d == ST_LOST);
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mux_sel_q   <= 2'd0;
      flush_cnt_q <= '0;
      prime_cnt_q <= '0;
      wd_q        <= '0;
      resync_q    <= 8'd0;
      sync_rst_q  <= 1'b1;
      locked_q    <= 1'b0;
      clk_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_sel_q   <= mux_sel_d;
      flush_cnt_q <= flush_cnt_d;
      prime_cnt_q <= prime_cnt_d;
      wd_q        <= wd_d;
      resync_q    <= resync_d;
      sync_rst_q  <= sync_rst_d;
      locked_q    <= locked_d;
      clk_lost_q  <= clk_lost_d;
    end
  end

  assign sync_rst     = sync_rst_q;
  assign mux_sel      = mux_sel_q;
  assign locked       = locked_q;
  assign clk_lost     = clk_lost_q;
  assign resync_count = resync_q;
  // Zero-latency qualifier; reset gate keeps it low before the first reset edge lands.
  assign bit_valid    = locked_q & bit_ok & ~reset;

endmodule

`default_nettype wire

// File: doc/bert_sync_ctrl.md
BERT_SYNC_CTRL -- requirements
Module: bert_sync_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 8: rd_clk cycles sync_rst is held per flush.
REQ-002 SHALL have parameter PRIME_BITS, default 4: valid bit enables to count before declaring lock.
REQ-003 SHALL have parameter LOSS_TIMEOUT, default 1024: rd_clk cycles without sync_enable before declaring clock loss.
REQ-004 SHALL have port rd_clk, input, 1: sole clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port src_sel, input, 2: requested input source.
REQ-007 SHALL have port sel_strobe, input, 1: single-cycle pulse that loads src_sel.
REQ-008 SHALL have port sync_enable, input, 1: per-bit enable pulse from the input sync stage.
REQ-009 SHALL have port sync_empty, input, 1: sync FIFO empty, already in the rd_clk domain.
REQ-010 SHALL have port sync_full, input, 1: sync FIFO full, already in the rd_clk domain.
REQ-011 SHALL have port sync_rst, output, 1: flush request to the sync stage.
REQ-012 SHALL have port mux_sel, output, 2: active source select.
REQ-013 SHALL have port bit_valid, output, 1: qualified bit enable to the BERT core.
REQ-014 SHALL have port locked, output, 1: high in RUN only.
REQ-015 SHALL have port clk_lost, output, 1: high in LOST only.
REQ-016 SHALL have port resync_count, output, 8: saturating count of error-driven resyncs.

Function
REQ-017 SHALL implement the states IDLE, FLUSH, PRIME, RUN and LOST.
REQ-018 IDLE SHALL go to FLUSH on the next cycle.
REQ-019 FLUSH SHALL drive sync_rst=1 and count exactly FLUSH_CYCLES cycles, then go to PRIME with the flush counter cleared.
REQ-020 PRIME SHALL count cycles with sync_enable & !sync_empty and go to RUN on the cycle the count reaches PRIME_BITS; bit_valid=0 in PRIME.
REQ-021 RUN SHALL drive bit_valid = sync_enable & !sync_empty, combinational, zero latency.
REQ-022 In RUN, sync_full=1, or sync_enable=1 with sync_empty=1, SHALL cause a transition to FLUSH and increment resync_count, saturating at 255.
REQ-023 A watchdog SHALL clear on every sync_enable and increment otherwise in all states except LOST.
REQ-024 When the watchdog reaches LOSS_TIMEOUT in PRIME or RUN, the block SHALL enter LOST.
REQ-025 LOST SHALL drive sync_rst=1 and clk_lost=1, and SHALL go to FLUSH on the first sync_enable without incrementing resync_count.
REQ-026 sel_strobe with src_sel != mux_sel in any state SHALL load mux_sel on the next edge and enter FLUSH with the flush counter restarted; resync_count is not incremented.
REQ-027 sel_strobe with src_sel == mux_sel SHALL be ignored.
REQ-028 Event priority SHALL be: reset > source change > watchdog timeout > full/empty error.
REQ-029 A strobe arriving during FLUSH SHALL restart the full FLUSH_CYCLES count.
REQ-030 Outputs SHALL be glitch-free registered decodes of state, except bit_valid (REQ-021).

Reset
REQ-031 On reset: state=IDLE, mux_sel=0, resync_count=0, and all counters cleared.
REQ-032 During reset: sync_rst=1, bit_valid=0, locked=0, clk_lost=0.
REQ-033 Reset asserted mid-operation SHALL abort any flush or prime on the same edge.

Structure
REQ-034 The state encoding and parameter defaults SHALL live in shared package bert_pkg.
REQ-035 No sub-module SHALL be used; watchdog and counters are inline.
REQ-036 The parent SHALL instantiate the input sync stage alongside this block, not inside it.

Verification
REQ-037 Reset release, then a sync_enable pulse every 4 cycles -> sync_rst high for 8 cycles, then locked after the 4th valid enable, and bit_valid pulses match sync_enable.
REQ-038 In RUN, force sync_full=1 for 1 cycle -> FLUSH next edge, resync_count=1, locked=0, and relock after 8+4 bits.
REQ-039 Stop sync_enable in RUN -> clk_lost=1 exactly 1024 cycles after the last pulse, then resume pulses -> FLUSH, then RUN, with resync_count unchanged.
REQ-040 In RUN, sel_strobe with src_sel=2 -> mux_sel=2 next edge and FLUSH; a second strobe with src_sel=3 at flush cycle 5 -> mux_sel=3 and flush lasts 8 further cycles.
REQ-041 Inject 300 full errors -> resync_count holds at 255.
REQ-042 Assert reset during PRIME -> all outputs at reset values on the next edge.
